// File: rtl/ext_wr_buffer.sv
// ext_wr_buffer: byte write buffer for the SoC external-bus port.
// SoC byte writes are pushed into a FIFO. They are drained to a downstream
// valid/ready byte sink, with an optional minimum idle gap between beats.
// Reads (i_ext_wstrb=0) complete immediately and do not push anything.
//
// Optional feature macro: EXT_WR_BUFFER_LEVEL_EN adds the o_level and
// o_high_water occupancy outputs.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_ext_valid/wstrb/addr/data  SoC request (one push per valid assertion)
//   o_ext_ready               combinational request-complete strobe
//   o_wr_valid/addr/data      registered downstream beat, held until accepted
//   i_wr_ready                downstream accept
//   o_empty                   registered: FIFO empty and no beat pending
//   o_level, o_high_water     (optional) current and peak occupancy
module ext_wr_buffer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ext_valid,
  input  logic              i_ext_wstrb,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [7:0]        i_ext_data,
  output logic              o_ext_ready,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_ready,
  output logic              o_empty
`ifdef EXT_WR_BUFFER_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] o_level,
  output logic [DEPTH_LOG2:0] o_high_water
`endif
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W   = DEPTH_LOG2 + 1;
  localparam int unsigned ENTRY_W = ADDR_W + 8;
  localparam int unsigned CNT_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_GAP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     gap_cnt, gap_cnt_nxt;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx, rd_idx_p1;
  logic                 acc_done, full, fifo_empty, push, pop;
  logic [ENTRY_W-1:0]   in_entry, head_entry, next_entry, load_entry;
  logic                 load;

  // FIFO status; the pointer MSB distinguishes full from empty
  assign wr_idx     = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx     = rd_ptr[DEPTH_LOG2-1:0];
  assign rd_idx_p1  = rd_idx + DEPTH_LOG2'(1);
  assign full       = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) && (wr_idx == rd_idx);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign level      = wr_ptr - rd_ptr;

  // Full blocks the push even if a pop happens in the same cycle
  assign push        = i_ext_valid & i_ext_wstrb & ~acc_done & ~full;
  assign pop         = o_wr_valid & i_wr_ready;
  assign o_ext_ready = i_ext_valid & (~i_ext_wstrb | acc_done | ~full);

  assign wr_ptr_nxt = wr_ptr + PTR_W'(push);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);

  // Head candidates: bypass the incoming write when it is the entry to present
  assign in_entry   = {i_ext_addr, i_ext_data};
  assign head_entry = fifo_empty ? in_entry : mem[rd_idx];
  assign next_entry = (level == PTR_W'(1)) ? in_entry : mem[rd_idx_p1];

  // FIFO storage (no reset; validity is tracked by the pointers)
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_idx] <= in_entry;
  end

  // Gap FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Gap FSM next state; load marks a new entry being copied to the output beat
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    load        = 1'b0;
    load_entry  = head_entry;
    case (state)
      S_IDLE: begin
        if (!fifo_empty || push) begin
          state_nxt = S_BEAT;
          load      = 1'b1;
        end
      end
      S_BEAT: begin
        if (pop) begin
          if (GAP_CYCLES != 0) begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = CNT_W'(GAP_CYCLES - 1);
          end else if ((level > PTR_W'(1)) || push) begin
            load       = 1'b1;
            load_entry = next_entry;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        // Leaving the gap straight into a beat keeps spacing at GAP_CYCLES+1
        if (gap_cnt == '0) begin
          if (!fifo_empty || push) begin
            state_nxt = S_BEAT;
            load      = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pointers, accept flag and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      acc_done   <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_empty    <= 1'b1;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      if (push) acc_done <= 1'b1;
      else if (!i_ext_valid) acc_done <= 1'b0;
      o_wr_valid <= (state_nxt == S_BEAT);
      if (load) {o_wr_addr, o_wr_data} <= load_entry;
      o_empty    <= (wr_ptr_nxt == rd_ptr_nxt) && (state_nxt != S_BEAT);
    end
  end

`ifdef EXT_WR_BUFFER_LEVEL_EN
  logic [PTR_W-1:0] level_nxt;
  assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

  // Occupancy and peak occupancy since reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_level      <= '0;
      o_high_water <= '0;
    end else begin
      o_level <= level_nxt;
      if (level_nxt > o_high_water) o_high_water <= level_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ext_wr_buffer.sv
// tb_ext_wr_buffer: directed and random checks of ext_wr_buffer against a
// queue-based model of the buffer (capacity, one-shot accept, FIFO order).
module tb_ext_wr_buffer;
  localparam int unsigned DL2   = 4;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1 << DL2;
  localparam int unsigned LW    = DL2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ext_valid, ext_wstrb, wr_ready;
  logic [AW-1:0] ext_addr;
  logic [7:0]    ext_data;
  logic          ext_ready, wr_valid, empty;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic          g_valid, g_wstrb, g_ready;
  logic [AW-1:0] g_addr;
  logic [7:0]    g_data;
  logic          g_ext_ready, g_wvalid, g_empty;
  logic [AW-1:0] g_waddr;
  logic [7:0]    g_wdata;
`ifdef EXT_WR_BUFFER_LEVEL_EN
  logic [LW-1:0] level, high_water, g_level, g_high_water;
`endif

  ext_wr_buffer #(.DEPTH_LOG2(DL2), .ADDR_W(AW), .GAP_CYCLES(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ext_valid(ext_valid), .i_ext_wstrb(ext_wstrb),
    .i_ext_addr(ext_addr), .i_ext_data(ext_data), .o_ext_ready(ext_ready),
    .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_wr_ready(wr_ready), .o_empty(empty)
`ifdef EXT_WR_BUFFER_LEVEL_EN
    , .o_level(level), .o_high_water(high_water)
`endif
  );

  ext_wr_buffer #(.DEPTH_LOG2(DL2), .ADDR_W(AW), .GAP_CYCLES(3)) dut_gap (
    .i_clk(clk), .i_rst_n(rst_n), .i_ext_valid(g_valid), .i_ext_wstrb(g_wstrb),
    .i_ext_addr(g_addr), .i_ext_data(g_data), .o_ext_ready(g_ext_ready),
    .o_wr_valid(g_wvalid), .o_wr_addr(g_waddr), .o_wr_data(g_wdata),
    .i_wr_ready(g_ready), .o_empty(g_empty)
`ifdef EXT_WR_BUFFER_LEVEL_EN
    , .o_level(g_level), .o_high_water(g_high_water)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of accepted {addr,data}, one-shot accept flag, peak level
  logic [AW+7:0] q[$];
  logic          m_acc;
  int            m_hw;
  int            beats;
  logic [AW+7:0] last_beat;
  logic          last_ready;
  logic          rand_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge with inputs already driven
  task automatic tick();
    logic exp_ready, exp_push, do_pop;
    if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
    #1;
    exp_ready = ext_valid & (~ext_wstrb | m_acc | (q.size() < DEPTH));
    exp_push  = ext_valid & ext_wstrb & ~m_acc & (q.size() < DEPTH);
    if (rst_n) begin
      chk("ext_ready", 32'(ext_ready), 32'(exp_ready));
      chk("wr_valid", 32'(wr_valid), 32'(q.size() != 0));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      if (q.size() != 0) chk("wr_beat", 32'({wr_addr, wr_data}), 32'(q[0]));
`ifdef EXT_WR_BUFFER_LEVEL_EN
      chk("level", 32'(level), 32'(q.size()));
      chk("high_water", 32'(high_water), 32'(m_hw));
`endif
    end
    last_ready = ext_ready;
    do_pop = wr_valid & wr_ready;
    if (do_pop) begin
      beats++;
      last_beat = {wr_addr, wr_data};
    end
    @(posedge clk);
    if (rst_n) begin
      if (do_pop && q.size() != 0) void'(q.pop_front());
      if (exp_push) q.push_back({ext_addr, ext_data});
      if (exp_push) m_acc = 1'b1;
      else if (!ext_valid) m_acc = 1'b0;
      if (q.size() > m_hw) m_hw = q.size();
    end
    @(negedge clk);
  endtask

  // SoC request: hold valid until ready, optionally longer, then drop for a cycle
  task automatic do_req(input logic ws, input logic [AW-1:0] a, input logic [7:0] d,
                        input int hold, output int waited);
    ext_valid = 1'b1; ext_wstrb = ws; ext_addr = a; ext_data = d; waited = 0;
    tick();
    while (!last_ready && waited < 300) begin
      waited++;
      tick();
    end
    chk("req_ready", 32'(last_ready), 32'd1);
    repeat (hold) tick();
    ext_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ext_valid = 1'b0; g_valid = 1'b0;
    #1;
    chk("rst_ext_ready", 32'(ext_ready), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
`ifdef EXT_WR_BUFFER_LEVEL_EN
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_high_water", 32'(high_water), 32'd0);
`endif
    q.delete(); m_acc = 1'b0; m_hw = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, b0, nb;
    int t_beat[4];
    logic [7:0] d_beat[4];

    rst_n = 1'b0; ext_valid = 1'b0; ext_wstrb = 1'b0; ext_addr = '0; ext_data = '0;
    wr_ready = 1'b0; g_valid = 1'b0; g_wstrb = 1'b1; g_addr = '0; g_data = '0;
    g_ready = 1'b0; rand_ready = 1'b0; beats = 0; last_beat = '0; last_ready = 1'b0;
    m_acc = 1'b0; m_hw = 0;
    @(negedge clk);
    do_reset();

    // Reset while draining three entries: nothing stale comes out afterwards
    for (int i = 0; i < 3; i++) do_req(1'b1, AW'(16'h0030 + i), 8'(8'h70 + i), 0, w);
    wr_ready = 1'b1;
    tick();
    do_reset();
    b0 = beats;
    repeat (8) tick();
    chk("t1_no_stale_beats", 32'(beats - b0), 32'd0);

    // Single write with valid held three cycles gives exactly one beat
    wr_ready = 1'b1;
    ext_valid = 1'b1; ext_wstrb = 1'b1; ext_addr = 16'h0012; ext_data = 8'hA5;
    b0 = beats;
    tick();
    chk("t2_ready_cycle0", 32'(last_ready), 32'd1);
    tick(); tick();
    ext_valid = 1'b0;
    repeat (4) tick();
    chk("t2_beat_count", 32'(beats - b0), 32'd1);
    chk("t2_beat_value", 32'(last_beat), 32'h0012A5);

    // Fill to capacity with the sink stalled; the 17th write must wait
    wr_ready = 1'b0;
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(16'h0100 + i), 8'(i * 7), 0, w);
    // A read while full completes immediately without a push
    do_req(1'b0, 16'h5555, 8'h00, 0, w);
    chk("t5_read_wait", 32'(w), 32'd0);
    ext_valid = 1'b1; ext_wstrb = 1'b1; ext_addr = 16'h0110; ext_data = 8'hEE;
    repeat (3) tick();
    chk("t3_blocked_at_full", 32'(last_ready), 32'd0);
    wr_ready = 1'b1;
    n = 0;
    tick();
    while (!last_ready && n < 10) begin
      n++;
      tick();
    end
    chk("t3_accept_delay", 32'(n), 32'd1);
    ext_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      tick();
    end
    tick();
    chk("t3_drained_last", 32'(last_beat), 32'h0110EE);

    // Gap instance: four queued writes drain exactly four cycles apart
    g_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g_valid = 1'b1; g_addr = AW'(16'h0200 + i); g_data = 8'(8'h40 + i);
      #1;
      chk("t4_accept", 32'(g_ext_ready), 32'd1);
      @(negedge clk);
      g_valid = 1'b0;
      @(negedge clk);
    end
    g_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (g_wvalid && g_ready) begin
        if (nb < 4) begin
          t_beat[nb] = c;
          d_beat[nb] = g_wdata;
        end
        nb++;
      end
      @(negedge clk);
    end
    chk("t4_beat_count", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_beat_data", 32'(d_beat[i]), 32'(8'h40 + i));
      if (i > 0) chk("t4_spacing", 32'(t_beat[i] - t_beat[i-1]), 32'd4);
    end

`ifdef EXT_WR_BUFFER_LEVEL_EN
    // Push 5, pop 2, push 1: occupancy 4, peak 5
    do_reset();
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_req(1'b1, AW'(16'h0300 + i), 8'(i), 0, w);
    wr_ready = 1'b1;
    tick(); tick();
    wr_ready = 1'b0;
    do_req(1'b1, 16'h0305, 8'h05, 0, w);
    chk("t6_level", 32'(level), 32'd4);
    chk("t6_high_water", 32'(high_water), 32'd5);
`endif

    // Random traffic with a randomly stalling sink
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      do_req(($urandom_range(0, 7) != 0), AW'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)), w);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    wr_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      tick();
    end
    tick();
    chk("rand_final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
